// File: rtl/line_buf_pkg.sv
// Shared types, default sizes and a constant-width helper for the multi-line buffer.
package line_buf_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_IMG_W  = 640;
  localparam int unsigned DEF_LINES  = 3;

  // Bits needed to index v entries; never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (((v - 1) >> i) != 0) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/line_delay_ram.sv
// One-line pixel delay: asynchronous read at addr, write at the same addr on we (read-before-write).
module line_delay_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata_c = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/fifo_multi_line_buffer.sv
// N-line sliding-window buffer for raster pixel streams with frame resync and fill tracking.
// Optional top-row replication during fill: define LINE_BUF_BORDER_REPLICATE_EN.
module fifo_multi_line_buffer
  import line_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned LINES  = DEF_LINES,
  parameter int unsigned ROW_W  = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we_i,
  input  logic                      sof_i,
  input  logic [DATA_W-1:0]         data_i,
  output logic [LINES*DATA_W-1:0]   data_o,
  output logic                      valid_o,
  output logic [clog2(IMG_W)-1:0]   col_o,
  output logic [ROW_W-1:0]          row_o,
  output logic                      line_done_o
);

  localparam int unsigned COL_W  = clog2(IMG_W);
  localparam int unsigned FILL_W = clog2(LINES);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX   = '1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LINES - 1);

  state_t              state;
  logic [COL_W-1:0]    ptr;
  logic [ROW_W-1:0]    row_cnt;
  logic [FILL_W-1:0]   fill_cnt;

  logic [COL_W-1:0]    col_c;
  logic [ROW_W-1:0]    row_c;
  logic [FILL_W-1:0]   fill_c;
  logic                wrap_c;
  logic [DATA_W-1:0]   lane_c [LINES];
  logic [DATA_W-1:0]   out_c  [LINES];
  logic [LINES*DATA_W-1:0] data_c;

  // A frame start forces this pixel to the origin regardless of the pointer.
  assign col_c  = sof_i ? '0 : ptr;
  assign row_c  = sof_i ? '0 : row_cnt;
  assign fill_c = sof_i ? '0 : fill_cnt;
  assign wrap_c = (col_c == COL_LAST);

  assign lane_c[0] = data_i;

  // Cascade: each RAM delays the previous lane by exactly one line.
  for (genvar k = 1; k < LINES; k++) begin : g_ram
    line_delay_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W),
      .ADDR_W (COL_W)
    ) u_ram (
      .clk     (clk),
      .we      (we_i),
      .addr    (col_c),
      .wdata   (lane_c[k-1]),
      .rdata_c (lane_c[k])
    );
  end

  for (genvar k = 0; k < LINES; k++) begin : g_out
`ifdef LINE_BUF_BORDER_REPLICATE_EN
    // Lanes above the frame's top row repeat the top row of this column.
    assign out_c[k] = (FILL_W'(k) > fill_c) ? lane_c[fill_c] : lane_c[k];
`else
    assign out_c[k] = lane_c[k];
`endif
    assign data_c[k*DATA_W +: DATA_W] = out_c[k];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
`ifdef LINE_BUF_BORDER_REPLICATE_EN
      state       <= RUN;
`else
      state       <= FILL;
`endif
      ptr         <= '0;
      row_cnt     <= '0;
      fill_cnt    <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      col_o       <= '0;
      row_o       <= '0;
      line_done_o <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      line_done_o <= 1'b0;
      if (we_i) begin
        data_o      <= data_c;
        col_o       <= col_c;
        row_o       <= row_c;
        line_done_o <= wrap_c;
`ifdef LINE_BUF_BORDER_REPLICATE_EN
        valid_o     <= (state == RUN);
        state       <= RUN;
`else
        valid_o     <= (state == RUN) && !sof_i;
        case (state)
          FILL: if (wrap_c && (fill_c == FILL_LAST - 1'b1)) state <= RUN;
          RUN:  if (sof_i) state <= FILL;
          default: state <= FILL;
        endcase
`endif
        if (wrap_c) begin
          ptr      <= '0;
          row_cnt  <= (row_c == ROW_MAX) ? row_c : row_c + 1'b1;
          fill_cnt <= (fill_c == FILL_LAST) ? fill_c : fill_c + 1'b1;
        end else begin
          ptr      <= col_c + 1'b1;
          row_cnt  <= row_c;
          fill_cnt <= fill_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_multi_line_buffer.sv
// Self-checking bench: random bubbles/resync/reset against a frame-history reference model.
module tb_fifo_multi_line_buffer;

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 4;
  localparam int unsigned LN = 3;
  localparam int unsigned RW = 3;
  localparam int unsigned CW = 2;

  logic              clk;
  logic              rst;
  logic              we_i;
  logic              sof_i;
  logic [DW-1:0]     data_i;
  logic [LN*DW-1:0]  data_o;
  logic              valid_o;
  logic [CW-1:0]     col_o;
  logic [RW-1:0]     row_o;
  logic              line_done_o;

  fifo_multi_line_buffer #(
    .DATA_W (DW),
    .IMG_W  (IW),
    .LINES  (LN),
    .ROW_W  (RW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we_i),
    .sof_i       (sof_i),
    .data_i      (data_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .col_o       (col_o),
    .row_o       (row_o),
    .line_done_o (line_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: absolute position in the frame plus every pixel written since frame start.
  int unsigned      m_row, m_col;
  logic [DW-1:0]    hist [int];
  logic [LN*DW-1:0] last_data;
  logic [CW-1:0]    last_col;
  logic [RW-1:0]    last_row;
  logic             last_full;
  int               rec_mode;
  logic [63:0]      q_exp [$];
  logic [63:0]      q_obs [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0;
    hist.delete();
    last_data = '0; last_col = '0; last_row = '0; last_full = 1'b1;
  endtask

  task automatic step(input logic we, input logic sof, input logic [DW-1:0] d);
    logic [LN*DW-1:0] e_data;
    logic             e_valid;
    int unsigned      src;
    we_i = we; sof_i = sof; data_i = d;
    @(posedge clk); #1;
    if (we) begin
      if (sof) begin m_row = 0; m_col = 0; hist.delete(); end
      hist[int'(m_row * IW + m_col)] = d;
`ifdef LINE_BUF_BORDER_REPLICATE_EN
      e_valid = 1'b1;
`else
      e_valid = (m_row >= LN - 1);
`endif
      for (int k = 0; k < LN; k++) begin
        src = (m_row >= k) ? m_row - k : 0;
        e_data[k*DW +: DW] = hist.exists(int'(src * IW + m_col)) ? hist[int'(src * IW + m_col)] : '0;
      end
      check("valid", 64'(valid_o), 64'(e_valid));
      check("col", 64'(col_o), 64'(m_col));
      check("row", 64'(row_o), 64'((m_row > 7) ? 7 : m_row));
      check("line_done", 64'(line_done_o), 64'(m_col == IW - 1));
      check("lane0", 64'(data_o[DW-1:0]), 64'(d));
      if (e_valid) check("window", 64'(data_o), 64'(e_data));
      if (rec_mode == 1 && e_valid)
        q_exp.push_back({29'd0, e_data, 5'(m_col), 3'((m_row > 7) ? 7 : m_row)});
      last_data = e_data; last_col = CW'(m_col);
      last_row = RW'((m_row > 7) ? 7 : m_row); last_full = e_valid;
      m_col++;
      if (m_col == IW) begin m_col = 0; m_row++; end
    end else begin
      check("idle_valid", 64'(valid_o), 64'd0);
      check("idle_line_done", 64'(line_done_o), 64'd0);
      check("hold_col", 64'(col_o), 64'(last_col));
      check("hold_row", 64'(row_o), 64'(last_row));
      check("hold_lane0", 64'(data_o[DW-1:0]), 64'(last_data[DW-1:0]));
      if (last_full) check("hold_window", 64'(data_o), 64'(last_data));
    end
    if (rec_mode == 2 && valid_o)
      q_obs.push_back({29'd0, data_o, 5'(col_o), 3'(row_o)});
    we_i = 1'b0; sof_i = 1'b0;
  endtask

  // Ramp pixels [from, to) of a frame: pixel = base + row*16 + col, sof on pixel 0.
  task automatic ramp(input int from, input int to, input logic [DW-1:0] base, input bit bubbles);
    for (int i = from; i < to; i++) begin
      if (bubbles) while ($urandom_range(1, 0) == 1) step(1'b0, 1'($urandom_range(1, 0)), DW'($urandom));
      step(1'b1, i == 0, DW'(int'(base) + (i / IW) * 16 + (i % IW)));
    end
  endtask

  initial begin
    rec_mode = 0;
    we_i = 1'b0; sof_i = 1'b0; data_i = '0;
    rst = 1'b0;
    model_reset();

    // Reset held with random strobes: everything stays cleared.
    for (int i = 0; i < 5; i++) begin
      we_i = 1'($urandom); sof_i = 1'($urandom); data_i = DW'($urandom);
      @(posedge clk); #1;
      check("rst_data", 64'(data_o), 64'd0);
      check("rst_valid", 64'(valid_o), 64'd0);
      check("rst_colrow", 64'({col_o, row_o}), 64'd0);
      check("rst_line_done", 64'(line_done_o), 64'd0);
    end
    we_i = 1'b0; sof_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    step(1'b1, 1'b0, 8'h5a);
    step(1'b0, 1'b0, 8'h00);

    // Ramp fill with continuous strobes, including row saturation.
    rec_mode = 1;
    ramp(0, 9, 8'h00, 1'b0);
`ifdef LINE_BUF_BORDER_REPLICATE_EN
    check("ninth_window", 64'(data_o), 64'h001020);
`else
    check("ninth_window", 64'(data_o), 64'h001020);
    check("ninth_valid", 64'(valid_o), 64'd1);
`endif
    ramp(9, 48, 8'h00, 1'b0);
    rec_mode = 0;

    // Same ramp with random bubbles: valid columns must match the continuous run.
    rec_mode = 2;
    ramp(0, 48, 8'h00, 1'b1);
    rec_mode = 0;
    check("bubble_count", 64'(q_obs.size()), 64'(q_exp.size()));
    for (int i = 0; i < q_exp.size() && i < q_obs.size(); i++)
      check("bubble_seq", q_obs[i], q_exp[i]);

    // Resync at row 3 col 2 with a distinguishable new frame.
    ramp(0, 14, 8'h00, 1'b1);
    ramp(0, 1, 8'h80, 1'b0);
`ifndef LINE_BUF_BORDER_REPLICATE_EN
    check("resync_valid_drop", 64'(valid_o), 64'd0);
`endif
    ramp(1, 9, 8'h80, 1'b0);
    check("resync_first_window", 64'(data_o), 64'h8090a0);
    ramp(9, 20, 8'h80, 1'b1);

    // Async reset mid-row at row 4 col 1.
    ramp(0, 17, 8'h00, 1'b0);
    @(negedge clk); rst = 1'b0; #1;
    check("async_rst_data", 64'(data_o), 64'd0);
    check("async_rst_valid", 64'(valid_o), 64'd0);
    check("async_rst_colrow", 64'({col_o, row_o}), 64'd0);
    model_reset();
    @(negedge clk); rst = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    ramp(0, 9, 8'h00, 1'b0);
    check("post_rst_window", 64'(data_o), 64'h001020);
    ramp(9, 24, 8'h00, 1'b0);

`ifdef LINE_BUF_BORDER_REPLICATE_EN
    // Top-row replication from the very first pixel.
    ramp(0, 1, 8'h00, 1'b0);
    check("rep_first_valid", 64'(valid_o), 64'd1);
    check("rep_first_window", 64'(data_o), 64'h000000);
    ramp(1, 6, 8'h00, 1'b0);
    check("rep_row1_window", 64'(data_o), 64'h010111);
    ramp(6, 16, 8'h00, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_multi_line_buffer.md
Name: fifo_multi_line_buffer

Overview:
Parametrised N-line sliding-window buffer for raster pixel streams. It generalises the fixed 3-row, 8-bit line buffer used ahead of the Sobel kernel to any pixel width, line length and tap count. It adds frame-start resynchronisation, fill tracking, a qualified output valid and column/row position outputs. It sits between the pixel source and any KxK window or convolution stage.

Parameters:
DATA_W, 8, pixel width in bits (>=1)
IMG_W, 640, pixels per line (>=2)
LINES, 3, vertical taps output, i.e. current line plus LINES-1 delayed lines (>=2)
ROW_W, 10, width of row_o counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
we_i  in  1  pixel strobe; one pixel accepted per cycle when high
sof_i  in  1  start of frame; qualified by we_i; marks the pixel as row 0, col 0
data_i  in  DATA_W  input pixel
data_o  out  LINES*DATA_W  lane k = bits [k*DATA_W +: DATA_W] = pixel k lines above, same column; lane 0 = current pixel
valid_o  out  1  data_o is a full, valid column
col_o  out  clog2(IMG_W)  column of lane 0
row_o  out  ROW_W  row of lane 0, saturating at 2^ROW_W-1
line_done_o  out  1  one-cycle pulse with the last pixel of each line

Behaviour:
- Reset (rst=0, async): data_o=0, valid_o=0, col_o=0, row_o=0, line_done_o=0, state=FILL, internal column/row/fill counters=0. RAM contents are not cleared.
- Storage: LINES-1 cascaded single-line delay RAMs, each IMG_W deep, sharing one column address pointer. Each RAM is read at the pointer and written at the same pointer in the same accepted cycle (read-before-write).
- Accepted cycle (we_i=1):
  - The pointer advances, wrapping IMG_W-1 -> 0.
  - On wrap, the row counter increments and line_done_o pulses.
  - If sof_i=1, this pixel is forced to col 0, row 0, the fill counter clears, and state -> FILL. This happens regardless of the current pointer.
- sof_i while we_i=0: ignored.
- we_i=0: no counter or RAM change; valid_o=0 next cycle; data_o, col_o and row_o hold.
- Latency: outputs are registered, 1 cycle after the accepted pixel.
- State machine:
  - FILL: valid_o=0.
  - FILL -> RUN on the wrap that completes line LINES-2, so the first valid_o coincides with row LINES-1, col 0.
  - RUN: valid_o = registered we_i.
  - RUN -> FILL only on sof_i or reset.
- A frame longer than 2^ROW_W rows saturates row_o; buffering is unaffected.
- Reset mid-line: on release, the next accepted pixel is col 0, row 0, and the buffer refills; stale RAM data is never flagged valid.

Optional Feature:
Macro: LINE_BUF_BORDER_REPLICATE_EN
- Defined: valid_o asserts from row 0 (state RUN immediately after sof_i or reset). For row r < LINES-1, lanes k > r output lane r (top-row replication) instead of stale RAM data.
- Undefined: valid_o is suppressed during FILL as described above, and no replication mux is built.

Decomposition:
- Shared package line_buf_pkg: state enum (FILL, RUN), the default DATA_W/IMG_W/LINES constants, and a clog2 function.
- One sub-module: line_delay_ram (DATA_W x IMG_W, single clock, read-before-write, external address), instantiated LINES-1 times in a generate loop.

Test Plan:
1. Reset: hold rst=0 for 5 cycles with we_i toggling -> all outputs 0, valid_o never rises; release, send 1 pixel -> col_o=0, row_o=0 one cycle later.
2. Ramp fill, with IMG_W=4, LINES=3, DATA_W=8, pixel=row*16+col, we_i continuous, sof_i on the first pixel:
   - valid_o stays 0 for 8 pixels.
   - The 9th pixel (0x20) gives valid_o=1, lane0=0x20, lane1=0x10, lane2=0x00, col_o=0, row_o=2.
   - line_done_o pulses on pixels 0x03, 0x13, 0x23.
3. Bubbles: same ramp with we_i randomly low 50% of cycles -> the sequence of (data_o, col_o, row_o) sampled on valid_o is identical to test 2.
4. Resync: assert sof_i with we_i at row 3, col 2 -> valid_o drops next cycle; the first valid afterwards is new row 2, col 0, with no stale lanes.
5. Async reset mid-row at row 4, col 1 -> outputs clear immediately; after release and a new frame, behaviour is identical to test 2.
6. With LINE_BUF_BORDER_REPLICATE_EN, same ramp:
   - Pixel 0x00 gives valid_o=1 with all lanes 0x00.
   - Pixel 0x11 gives lanes {0x11, 0x01, 0x01}.
   - From row 2 on, the output is identical to test 2.
